// File: rtl/memctrl_arb.sv
// -----------------------------------------------------------------------------
// memctrl_arb
//
// Byte-serial RAM controller that arbitrates three requesters onto one
// byte-wide synchronous RAM port:
//   - store  (st_*) : 1, 2 or 4 byte writes from the store buffer
//   - load   (ld_*) : 1..4 byte reads, extended and broadcast on the CDB
//   - fetch  (fc_*) : LINE_BYTES byte icache line reads
//
// Parameters
//   LINE_BYTES : bytes per icache line (power of two, 4..64)
//   ADDR_W     : byte address width
//   TAG_W      : ROB index width
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   rdy             : global ready, low freezes every register
//   rollback        : kills a load in progress and blocks a pending one
//   fc_valid/addr   : fetch request, fc_done/fc_line : fetched line
//   st_valid/addr/data/len : store request, st_done : store finished
//   ld_valid/addr/len/sext/tag : load request
//   ld_done/ld_tag_out/ld_data : load result (ld_done is the CDB enable)
//   io_full         : IO write buffer full (back-pressure on IO writes)
//   ram_wr/ram_addr/ram_dout/ram_din : RAM port, read data one cycle late
//
// Handshake: every request is a level held by the requester from the cycle it
// is raised until the cycle its done pulse is seen. The controller samples
// requests only in IDLE; a channel whose done is high in the current cycle is
// treated as idle so the still-high valid cannot relaunch it.
//
// The current FSM state is held in the enum register 'state' so checkers can
// bind to it directly.
// -----------------------------------------------------------------------------
module memctrl_arb #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32,
  parameter int TAG_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,

  input  logic                    fc_valid,
  input  logic [ADDR_W-1:0]       fc_addr,
  output logic                    fc_done,
  output logic [8*LINE_BYTES-1:0] fc_line,

  input  logic                    st_valid,
  input  logic [ADDR_W-1:0]       st_addr,
  input  logic [31:0]             st_data,
  input  logic [1:0]              st_len,
  output logic                    st_done,

  input  logic                    ld_valid,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [1:0]              ld_len,
  input  logic                    ld_sext,
  input  logic [TAG_W-1:0]        ld_tag,
  output logic                    ld_done,
  output logic [TAG_W-1:0]        ld_tag_out,
  output logic [31:0]             ld_data,

  input  logic                    io_full,
  output logic                    ram_wr,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [7:0]              ram_dout,
  input  logic [7:0]              ram_din
);

  localparam int CW = $clog2(LINE_BYTES) + 1;
  localparam int LW = 8 * LINE_BYTES;
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_LOAD  = 2'd2,
    S_FETCH = 2'd3
  } state_t;

  state_t            state;

  // cnt: in STORE the index of the byte currently on ram_dout; in LOAD/FETCH
  // the number of cycles spent in the state, so byte cnt-1 is on ram_din.
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     last;       // index of the final byte (N-1)
  logic [CW-1:0]     cnt_inc;
  logic [CW-1:0]     cap_idx;

  logic [LW-1:0]     line_buf;   // bytes captured so far
  logic [LW-1:0]     line_next;  // line_buf with this cycle's ram_din merged in

  logic [31:0]       st_data_q;
  logic [1:0]        ld_len_q;
  logic              ld_sext_q;
  logic [TAG_W-1:0]  ld_tag_q;

  logic              wr_q;       // a write byte is being presented
  logic              io_stall;

  logic              st_elig;
  logic              ld_elig;
  logic              fc_elig;

  // Byte, half, three-byte or word result with optional sign extension.
  function automatic logic [31:0] extend(input logic [31:0] w,
                                         input logic [1:0]  len,
                                         input logic        sext);
    logic [31:0] r;
    r = w;
    case (len)
      2'd0:    r = {{24{sext & w[7]}},  w[7:0]};
      2'd1:    r = {{16{sext & w[15]}}, w[15:0]};
      2'd2:    r = {8'h00, w[23:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Writes into the IO region (address bits 17:16 both set) must wait while
  // the IO write buffer is full. The write strobe is dropped in the same cycle
  // so the byte is never presented twice; address/count simply hold.
  assign io_stall = wr_q && (ram_addr[17:16] == 2'b11) && io_full;
  assign ram_wr   = wr_q && !io_stall;

  assign st_elig = st_valid && !st_done;
  assign ld_elig = ld_valid && !ld_done && !rollback;
  assign fc_elig = fc_valid && !fc_done;

  assign cnt_inc = cnt + CNT_ONE;
  assign cap_idx = cnt - CNT_ONE;

  always_comb begin
    line_next = line_buf;
    if (cnt != '0) begin
      line_next[{cap_idx, 3'b000} +: 8] = ram_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last       <= '0;
      line_buf   <= '0;
      st_data_q  <= '0;
      ld_len_q   <= '0;
      ld_sext_q  <= 1'b0;
      ld_tag_q   <= '0;
      wr_q       <= 1'b0;
      ram_addr   <= '0;
      ram_dout   <= '0;
      st_done    <= 1'b0;
      ld_done    <= 1'b0;
      fc_done    <= 1'b0;
      fc_line    <= '0;
      ld_data    <= '0;
      ld_tag_out <= '0;
    end else if (rdy) begin
      // Done outputs are single-cycle pulses.
      st_done <= 1'b0;
      ld_done <= 1'b0;
      fc_done <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (st_elig) begin
            state     <= S_STORE;
            ram_addr  <= st_addr;
            wr_q      <= 1'b1;
            ram_dout  <= st_data[7:0];
            st_data_q <= st_data;
            last      <= CW'(st_len);
          end else if (ld_elig) begin
            state     <= S_LOAD;
            ram_addr  <= ld_addr;
            wr_q      <= 1'b0;
            last      <= CW'(ld_len);
            ld_len_q  <= ld_len;
            ld_sext_q <= ld_sext;
            ld_tag_q  <= ld_tag;
          end else if (fc_elig) begin
            state     <= S_FETCH;
            ram_addr  <= fc_addr;
            wr_q      <= 1'b0;
            last      <= CW'(LINE_BYTES - 1);
          end
        end

        S_STORE: begin
          if (!io_stall) begin
            if (cnt < last) begin
              cnt      <= cnt_inc;
              ram_addr <= ram_addr + ADDR_ONE;
              ram_dout <= st_data_q[{cnt_inc[1:0], 3'b000} +: 8];
            end else begin
              wr_q     <= 1'b0;
              ram_addr <= '0;
              ram_dout <= '0;
              st_done  <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end

        S_LOAD, S_FETCH: begin
          if (state == S_LOAD && rollback) begin
            // Squashed load: drop it without a CDB broadcast.
            ram_addr <= '0;
            state    <= S_IDLE;
          end else begin
            if (cnt != '0) begin
              line_buf <= line_next;
            end
            // Addresses run one cycle ahead of the captured data.
            if (cnt < last) begin
              ram_addr <= ram_addr + ADDR_ONE;
            end
            if (cnt == last + CNT_ONE) begin
              ram_addr <= '0;
              state    <= S_IDLE;
              if (state == S_LOAD) begin
                ld_done    <= 1'b1;
                ld_data    <= extend(line_next[31:0], ld_len_q, ld_sext_q);
                ld_tag_out <= ld_tag_q;
              end else begin
                fc_done    <= 1'b1;
                fc_line    <= line_next;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memctrl_arb.sv
// -----------------------------------------------------------------------------
// tb_memctrl_arb
//
// Two controller instances (16- and 32-byte lines) share one RAM model that
// returns read data one cycle after the address and freezes with rdy.
// A table of load vectors is replayed in a loop; hand-written sequences cover
// arbitration, IO back-pressure, rollback, rdy freeze and reset mid-transfer.
// Expected results are queued when a request is driven and popped by a
// monitor when the matching done pulse appears.
// -----------------------------------------------------------------------------
module tb_memctrl_arb;

  localparam int LB  = 16;
  localparam int LB2 = 32;
  localparam int AW  = 32;
  localparam int TW  = 4;
  localparam int LW  = 8 * LB;
  localparam int LW2 = 8 * LB2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rdy, rollback;

  // ---------------- DUT (16-byte line) signals ----------------
  logic          fc_valid;
  logic [AW-1:0] fc_addr;
  logic          fc_done;
  logic [LW-1:0] fc_line;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [1:0]    st_len;
  logic          st_done;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [1:0]    ld_len;
  logic          ld_sext;
  logic [TW-1:0] ld_tag;
  logic          ld_done;
  logic [TW-1:0] ld_tag_out;
  logic [31:0]   ld_data;
  logic          io_full;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  // ---------------- DUT (32-byte line) signals ----------------
  logic           fc_valid2;
  logic           fc_done2;
  logic [LW2-1:0] fc_line2;
  logic           b_st_done, b_ld_done, b_ram_wr;
  logic [TW-1:0]  b_ld_tag;
  logic [31:0]    b_ld_data;
  logic [7:0]     b_ram_dout;
  logic [AW-1:0]  ram_addr2;
  logic [7:0]     ram_din2;

  memctrl_arb #(.LINE_BYTES(LB), .ADDR_W(AW), .TAG_W(TW)) u_dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .fc_valid(fc_valid), .fc_addr(fc_addr), .fc_done(fc_done), .fc_line(fc_line),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_len(st_len),
    .st_done(st_done),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_len(ld_len), .ld_sext(ld_sext),
    .ld_tag(ld_tag), .ld_done(ld_done), .ld_tag_out(ld_tag_out), .ld_data(ld_data),
    .io_full(io_full), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .ram_din(ram_din)
  );

  memctrl_arb #(.LINE_BYTES(LB2), .ADDR_W(AW), .TAG_W(TW)) u_dut32 (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(1'b0),
    .fc_valid(fc_valid2), .fc_addr(fc_addr), .fc_done(fc_done2), .fc_line(fc_line2),
    .st_valid(1'b0), .st_addr('0), .st_data(32'h0), .st_len(2'd0),
    .st_done(b_st_done),
    .ld_valid(1'b0), .ld_addr('0), .ld_len(2'd0), .ld_sext(1'b0),
    .ld_tag('0), .ld_done(b_ld_done), .ld_tag_out(b_ld_tag), .ld_data(b_ld_data),
    .io_full(1'b0), .ram_wr(b_ram_wr), .ram_addr(ram_addr2), .ram_dout(b_ram_dout),
    .ram_din(ram_din2)
  );

  // ---------------- RAM model ----------------
  logic [7:0]  mem [0:262143];
  logic [25:0] wr_log[$];

  always @(posedge clk) begin
    if (rdy) begin
      if (ram_wr) begin
        mem[ram_addr[17:0]] <= ram_dout;
        wr_log.push_back({ram_addr[17:0], ram_dout});
      end
      ram_din  <= mem[ram_addr[17:0]];
      ram_din2 <= mem[ram_addr2[17:0]];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [31:0]    exp_ld_q[$];
  logic [TW-1:0]  exp_tag_q[$];
  logic [0:0]     exp_st_q[$];
  logic [LW-1:0]  exp_fc_q[$];
  logic [LW2-1:0] exp_fc2_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=done expected=no_done", name);
  endtask

  // A done pulse held over rdy-low cycles is one event; count it when rdy is high.
  always @(negedge clk) begin
    if (!rst && rdy) begin
      if (ld_done) begin
        if (exp_ld_q.size() == 0) unexpected("ld_done_unexpected");
        else begin
          chk("ld_data", ld_data, exp_ld_q.pop_front());
          chk("ld_tag_out", ld_tag_out, exp_tag_q.pop_front());
        end
      end
      if (st_done) begin
        if (exp_st_q.size() == 0) unexpected("st_done_unexpected");
        else void'(exp_st_q.pop_front());
      end
      if (fc_done) begin
        if (exp_fc_q.size() == 0) unexpected("fc_done_unexpected");
        else chk("fc_line", fc_line, exp_fc_q.pop_front());
      end
      if (fc_done2) begin
        if (exp_fc2_q.size() == 0) unexpected("fc32_done_unexpected");
        else chk("fc32_line", fc_line2, exp_fc2_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_ld(input int a, input int len, input logic sext);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i <= len; i++) w[i*8 +: 8] = mem[a + i];
    if (sext && len == 0 && w[7])  w[31:8]  = '1;
    if (sext && len == 1 && w[15]) w[31:16] = '1;
    return w;
  endfunction

  logic [LW-1:0]  line16;
  logic [LW2-1:0] line32;

  // ---------------- driver tasks ----------------
  task automatic run_load(input string name, input logic [AW-1:0] a, input logic [1:0] len,
                          input logic sext, input logic [TW-1:0] tag,
                          input logic [31:0] exp_data, input int exp_lat);
    int lat;
    lat = 0;
    exp_ld_q.push_back(exp_data);
    exp_tag_q.push_back(tag);
    ld_addr = a; ld_len = len; ld_sext = sext; ld_tag = tag; ld_valid = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (ld_done) begin lat = k; break; end
    end
    ld_valid = 1'b0;
    chk({name, "_lat"}, lat, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic run_store(input string name, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [1:0] len, input int stall_at, input int stall_n,
                           input int exp_lat);
    int lat;
    lat = 0;
    exp_st_q.push_back(1'b1);
    st_addr = a; st_data = d; st_len = len; st_valid = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      io_full = (k >= stall_at) && (k < stall_at + stall_n);
      if (st_done) begin lat = k; break; end
    end
    st_valid = 1'b0;
    io_full  = 1'b0;
    chk({name, "_lat"}, lat, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic run_fetch32(input logic [AW-1:0] a, input int exp_lat);
    int lat;
    lat = 0;
    exp_fc2_q.push_back(line32);
    fc_addr = a; fc_valid2 = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (fc_done2) begin lat = k; break; end
    end
    fc_valid2 = 1'b0;
    chk("fc32_lat", lat, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic run_fetch(input logic [AW-1:0] a, input int exp_lat);
    int lat;
    lat = 0;
    exp_fc_q.push_back(line16);
    fc_addr = a; fc_valid = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (fc_done) begin lat = k; break; end
    end
    fc_valid = 1'b0;
    chk("fc_lat", lat, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_ram_addr"}, ram_addr, 0);
    chk({name, "_ram_wr"}, ram_wr, 0);
    chk({name, "_ram_dout"}, ram_dout, 0);
    chk({name, "_ld_data"}, ld_data, 0);
    chk({name, "_ld_tag_out"}, ld_tag_out, 0);
    chk({name, "_fc_line"}, fc_line, 0);
    chk({name, "_dones"}, {st_done, ld_done, fc_done}, 0);
  endtask

  // ---------------- load vector table ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    len;
    logic          sext;
    logic [TW-1:0] tag;
    logic [31:0]   exp_data;
    int            exp_lat;
  } ld_vec_t;

  ld_vec_t vecs [7];

  int k_st, k_ld, k_fc, ld_seen, st_seen;

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{32'h100, 2'd3, 1'b1, 4'd5, 32'h84332211, 6};
    vecs[1] = '{32'h103, 2'd0, 1'b1, 4'd1, 32'hFFFFFF84, 3};
    vecs[2] = '{32'h103, 2'd0, 1'b0, 4'd2, 32'h00000084, 3};
    vecs[3] = '{32'h102, 2'd1, 1'b1, 4'd3, 32'hFFFF8433, 4};
    vecs[4] = '{32'h102, 2'd1, 1'b0, 4'd4, 32'h00008433, 4};
    vecs[5] = '{32'h100, 2'd2, 1'b1, 4'd6, 32'h00332211, 5};
    vecs[6] = '{32'h100, 2'd1, 1'b1, 4'd7, 32'h00002211, 4};

    for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
    for (int i = 'h104; i < 'h200; i++) mem[i] = 8'($urandom_range(0, 255));
    mem['h100] = 8'h11; mem['h101] = 8'h22; mem['h102] = 8'h33; mem['h103] = 8'h84;
    for (int i = 0; i < LB2; i++) mem['h200 + i] = 8'(i);
    for (int i = 0; i < LB; i++)  line16[i*8 +: 8] = 8'(i);
    for (int i = 0; i < LB2; i++) line32[i*8 +: 8] = 8'(i);

    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_full = 1'b0;
    fc_valid = 1'b0; fc_valid2 = 1'b0; fc_addr = '0;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_len = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_len = '0; ld_sext = 1'b0; ld_tag = '0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    chk("reset_dut32", {b_st_done, b_ld_done, b_ram_wr, b_ld_tag, b_ld_data, b_ram_dout,
                        ram_addr2, fc_done2, fc_line2}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven loads.
    for (int i = 0; i < 7; i++) begin
      run_load($sformatf("ld_vec%0d", i), vecs[i].addr, vecs[i].len, vecs[i].sext,
               vecs[i].tag, vecs[i].exp_data, vecs[i].exp_lat);
    end

    // Random loads from the randomly filled region.
    for (int i = 0; i < 4; i++) begin
      int a, len;
      logic sx;
      a   = 'h104 + $urandom_range(0, 'hF0);
      len = $urandom_range(0, 3);
      sx  = 1'($urandom_range(0, 1));
      run_load($sformatf("ld_rand%0d", i), AW'(a), 2'(len), sx, TW'(i + 8),
               model_ld(a, len, sx), len + 3);
    end

    // Stores, read back through the load channel.
    run_store("st_word", 32'h400, 32'hDEADBEEF, 2'd3, 0, 0, 5);
    run_load("ld_word_back", 32'h400, 2'd3, 1'b0, 4'd9, 32'hDEADBEEF, 6);
    run_store("st_half", 32'h404, 32'h0000C3A5, 2'd1, 0, 0, 3);
    run_load("ld_half_back", 32'h404, 2'd1, 1'b1, 4'd10, 32'hFFFFC3A5, 4);
    run_store("st_byte", 32'h406, 32'h0000007E, 2'd0, 0, 0, 2);
    run_load("ld_mix_back", 32'h404, 2'd3, 1'b0, 4'd11, 32'h007EC3A5, 6);

    // IO-region store with io_full high for 3 cycles while byte 1 is presented.
    wr_log.delete();
    run_store("st_io", 32'h30000, 32'h44332211, 2'd3, 2, 3, 8);
    chk("io_wr_count", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      chk("io_wr0", wr_log[0], {18'h30000, 8'h11});
      chk("io_wr1", wr_log[1], {18'h30001, 8'h22});
      chk("io_wr2", wr_log[2], {18'h30002, 8'h33});
      chk("io_wr3", wr_log[3], {18'h30003, 8'h44});
    end

    // Line fetches for both line lengths.
    run_fetch(32'h200, 18);
    run_fetch32(32'h200, 34);

    // Simultaneous requests: store, then load (of the stored word), then fetch.
    exp_st_q.push_back(1'b1);
    exp_ld_q.push_back(32'h12345678);
    exp_tag_q.push_back(4'd7);
    exp_fc_q.push_back(line16);
    st_addr = 32'h500; st_data = 32'h12345678; st_len = 2'd3;
    ld_addr = 32'h500; ld_len = 2'd3; ld_sext = 1'b0; ld_tag = 4'd7;
    fc_addr = 32'h200;
    st_valid = 1'b1; ld_valid = 1'b1; fc_valid = 1'b1;
    k_st = 0; k_ld = 0; k_fc = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (st_done && k_st == 0) begin k_st = k; st_valid = 1'b0; end
      if (ld_done && k_ld == 0) begin k_ld = k; ld_valid = 1'b0; end
      if (fc_done && k_fc == 0) begin k_fc = k; fc_valid = 1'b0; end
      if (k_st != 0 && k_ld != 0 && k_fc != 0) break;
    end
    st_valid = 1'b0; ld_valid = 1'b0; fc_valid = 1'b0;
    chk("arb_st_lat", k_st, 5);
    chk("arb_ld_lat", k_ld, 11);
    chk("arb_fc_lat", k_fc, 29);
    repeat (3) @(posedge clk);
    #1;

    // Rollback in cycle t+3 of a word load with a fetch pending behind it.
    exp_fc_q.push_back(line16);
    ld_addr = 32'h100; ld_len = 2'd3; ld_sext = 1'b1; ld_tag = 4'd2;
    fc_addr = 32'h200;
    ld_valid = 1'b1; fc_valid = 1'b1;
    k_fc = 0; ld_seen = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (ld_done) ld_seen++;
      if (k == 3) begin rollback = 1'b1; ld_valid = 1'b0; end
      if (k == 4) begin
        rollback = 1'b0;
        chk("rb_ram_addr", ram_addr, 0);
      end
      if (k == 5) chk("rb_fc_addr", ram_addr, 32'h200);
      if (fc_done) begin k_fc = k; break; end
    end
    fc_valid = 1'b0;
    chk("rb_fc_lat", k_fc, 22);
    chk("rb_no_ld_done", ld_seen, 0);
    @(posedge clk); #1;

    // rdy low for 4 cycles mid-fetch.
    exp_fc_q.push_back(line16);
    fc_addr = 32'h200; fc_valid = 1'b1;
    k_fc = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin chk("frz_addr_t5", ram_addr, 32'h204); rdy = 1'b0; end
      if (k == 8) chk("frz_addr_t8", ram_addr, 32'h204);
      if (k == 9) begin chk("frz_addr_t9", ram_addr, 32'h204); rdy = 1'b1; end
      if (fc_done) begin k_fc = k; break; end
    end
    fc_valid = 1'b0;
    rdy = 1'b1;
    chk("frz_fc_lat", k_fc, 22);
    @(posedge clk); #1;

    // Reset in the middle of a word store.
    st_addr = 32'h600; st_data = 32'hCAFEF00D; st_len = 2'd3; st_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; st_valid = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("rst_mid");
    rst = 1'b0;
    st_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (st_done) st_seen++;
    end
    chk("rst_no_st_done", st_seen, 0);
    chk("rst_mem601", mem['h601], 8'hF0);
    chk("rst_mem602", mem['h602], 8'h00);

    chk("sb_empty", {exp_ld_q.size(), exp_st_q.size(), exp_fc_q.size(), exp_fc2_q.size()}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
